// File: rtl/bfu_pipe.sv
// Three-stage pipelined radix-2 DIT butterfly: Ya = Xa + Xb*W, Yb = Xa - Xb*W.
// It includes a twiddle conjugate for the inverse FFT, optional /2 scaling, saturation and a sticky overflow flag.
module bfu_pipe #(
    parameter int DW    = 16,
    parameter int FRAC  = 14,
    parameter int SCALE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 conj_w,
    input  logic signed [DW-1:0] Xar,
    input  logic signed [DW-1:0] Xai,
    input  logic signed [DW-1:0] Xbr,
    input  logic signed [DW-1:0] Xbi,
    input  logic signed [DW-1:0] Wr,
    input  logic signed [DW-1:0] Wi,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] Yar,
    output logic signed [DW-1:0] Yai,
    output logic signed [DW-1:0] Ybr,
    output logic signed [DW-1:0] Ybi,
    output logic                 ovf,
    input  logic                 ovf_clr
);
    localparam int PW = 2 * DW;
    localparam logic signed [DW-1:0] MAXV  = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] MINV  = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [DW+1:0] MAX_X = (DW+2)'(MAXV);
    localparam logic signed [DW+1:0] MIN_X = (DW+2)'(MINV);
    localparam logic signed [DW+1:0] ONE_X = $signed({{(DW+1){1'b0}}, 1'b1});
    localparam logic signed [PW:0]   RND   = {{(PW-FRAC+1){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

    logic                 en;
    logic signed [DW-1:0] wi_c;
    logic signed [PW-1:0] xbr_x, xbi_x, wr_x, wi_x;

    logic                 s1_valid_q;
    logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
    logic signed [DW-1:0] s1_xar_q, s1_xai_q;

    logic signed [PW:0]   pr_full, pi_full, pr_rnd, pi_rnd;
    logic                 s2_valid_q;
    logic signed [DW:0]   pr_q, pi_q;
    logic signed [DW-1:0] s2_xar_q, s2_xai_q;

    logic [3:0]           sat;
    logic signed [DW-1:0] y_d [4];
    logic signed [DW-1:0] y_q [4];
    logic                 out_valid_q;
    logic                 ovf_q, ovf_d;
    logic                 unused_bits;

    assign en       = ~out_valid_q | out_ready;
    assign in_ready = en;

    // Negating the most negative twiddle would wrap, so it clamps to the largest positive value.
    always_comb begin
        wi_c = Wi;
        if (conj_w) begin
            wi_c = (Wi == MINV) ? MAXV : -Wi;
        end
    end

    assign xbr_x = PW'(Xbr);
    assign xbi_x = PW'(Xbi);
    assign wr_x  = PW'(Wr);
    assign wi_x  = PW'(wi_c);

    assign pr_full = (PW+1)'(p_rr_q) - (PW+1)'(p_ii_q);
    assign pi_full = (PW+1)'(p_ri_q) + (PW+1)'(p_ir_q);
    assign pr_rnd  = pr_full + RND;
    assign pi_rnd  = pi_full + RND;
    // Only DW+1 bits of the rounded product are kept; the rest is sign or discarded fraction for |W| <= 1.
    assign unused_bits = ^{pr_rnd[FRAC-1:0], pr_rnd[PW:FRAC+DW+1], pi_rnd[FRAC-1:0], pi_rnd[PW:FRAC+DW+1]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_out
            logic signed [DW+1:0] a_x, p_x, s_x, s_sc;
            assign a_x  = (DW+2)'((gi % 2 == 0) ? s2_xar_q : s2_xai_q);
            assign p_x  = (DW+2)'((gi % 2 == 0) ? pr_q : pi_q);
            assign s_x  = (gi < 2) ? (a_x + p_x) : (a_x - p_x);
            assign s_sc = (SCALE != 0) ? ((s_x + ONE_X) >>> 1) : s_x;
            assign sat[gi] = (s_sc > MAX_X) || (s_sc < MIN_X);
            assign y_d[gi] = (s_sc > MAX_X) ? MAXV :
                             (s_sc < MIN_X) ? MINV : s_sc[DW-1:0];
        end
    endgenerate

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (en && s2_valid_q && (|sat)) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            p_rr_q   <= xbr_x * wr_x;
            p_ii_q   <= xbi_x * wi_x;
            p_ri_q   <= xbr_x * wi_x;
            p_ir_q   <= xbi_x * wr_x;
            s1_xar_q <= Xar;
            s1_xai_q <= Xai;
            pr_q     <= pr_rnd[FRAC+DW:FRAC];
            pi_q     <= pi_rnd[FRAC+DW:FRAC];
            s2_xar_q <= s1_xar_q;
            s2_xai_q <= s1_xai_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                y_q[i] <= '0;
            end
        end else begin
            ovf_q <= ovf_d;
            if (en) begin
                s1_valid_q  <= in_valid;
                s2_valid_q  <= s1_valid_q;
                out_valid_q <= s2_valid_q;
                for (int i = 0; i < 4; i++) begin
                    y_q[i] <= y_d[i];
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;
    assign Yar       = y_q[0];
    assign Yai       = y_q[1];
    assign Ybr       = y_q[2];
    assign Ybi       = y_q[3];
endmodule

// File: tb/tb_bfu_pipe.sv
// Bench for bfu_pipe: an unscaled and a scaled instance share stimulus and are checked against an integer reference model.
module tb_bfu_pipe;
    logic clk = 1'b0;
    logic rst, in_valid, conj_w, out_ready, ovf_clr;
    logic signed [15:0] Xar, Xai, Xbr, Xbi, Wr, Wi;
    logic in_ready0, out_valid0, ovf0, in_ready1, out_valid1, ovf1;
    logic signed [15:0] Yar0, Yai0, Ybr0, Ybi0, Yar1, Yai1, Ybr1, Ybi1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic signed [15:0] ar0, ai0, br0, bi0, ar1, ai1, br1, bi1;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    bfu_pipe #(.DW(16), .FRAC(14), .SCALE(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .conj_w(conj_w),
        .Xar(Xar), .Xai(Xai), .Xbr(Xbr), .Xbi(Xbi), .Wr(Wr), .Wi(Wi),
        .out_valid(out_valid0), .out_ready(out_ready),
        .Yar(Yar0), .Yai(Yai0), .Ybr(Ybr0), .Ybi(Ybi0), .ovf(ovf0), .ovf_clr(ovf_clr)
    );
    bfu_pipe #(.DW(16), .FRAC(14), .SCALE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .conj_w(conj_w),
        .Xar(Xar), .Xai(Xai), .Xbr(Xbr), .Xbi(Xbi), .Wr(Wr), .Wi(Wi),
        .out_valid(out_valid1), .out_ready(out_ready),
        .Yar(Yar1), .Yai(Yai1), .Ybr(Ybr1), .Ybi(Ybi1), .ovf(ovf1), .ovf_clr(ovf_clr)
    );

    function automatic logic signed [15:0] clamp(input longint v);
        if (v > 32767) return 16'sh7fff;
        if (v < -32768) return 16'sh8000;
        return 16'(v);
    endfunction

    function automatic exp_t model(input logic signed [15:0] ar, ai, br, bi, w_r, w_i, input logic cj);
        exp_t e;
        longint wip, pr, pim, p_r, p_i;
        longint s[4];
        logic signed [16:0] tr, ti;
        wip = longint'(w_i);
        if (cj) wip = (w_i == -16'sd32768) ? 32767 : -longint'(w_i);
        pr  = longint'(br) * longint'(w_r) - longint'(bi) * wip;
        pim = longint'(br) * wip + longint'(bi) * longint'(w_r);
        tr  = 17'((pr + 8192) >>> 14);
        ti  = 17'((pim + 8192) >>> 14);
        p_r = tr;
        p_i = ti;
        s[0] = longint'(ar) + p_r;
        s[1] = longint'(ai) + p_i;
        s[2] = longint'(ar) - p_r;
        s[3] = longint'(ai) - p_i;
        e.ar0 = clamp(s[0]); e.ai0 = clamp(s[1]); e.br0 = clamp(s[2]); e.bi0 = clamp(s[3]);
        e.ar1 = clamp((s[0] + 1) >>> 1); e.ai1 = clamp((s[1] + 1) >>> 1);
        e.br1 = clamp((s[2] + 1) >>> 1); e.bi1 = clamp((s[3] + 1) >>> 1);
        return e;
    endfunction

    task automatic set_in(input int ar, ai, br, bi, w_r, w_i, input logic cj);
        Xar = 16'(ar); Xai = 16'(ai); Xbr = 16'(br); Xbi = 16'(bi);
        Wr = 16'(w_r); Wi = 16'(w_i); conj_w = cj;
    endtask

    task automatic rand_in();
        int w_r, w_i;
        do begin
            w_r = int'($urandom_range(32768)) - 16384;
            w_i = int'($urandom_range(32768)) - 16384;
        end while (w_r * w_r + w_i * w_i > 268435456);
        set_in(int'(16'($urandom)) , int'(16'($urandom)), int'(16'($urandom)),
               int'(16'($urandom)), w_r, w_i, 1'($urandom));
    endtask

    // Sends the current input once into an empty pipe with out_ready low; lat = edges until out_valid, -1 on timeout.
    task automatic send_wait(output int lat);
        logic acc;
        lat = -1;
        @(posedge clk); #1 in_valid = 1'b1;
        @(negedge clk); acc = in_ready0;
        @(posedge clk); #1 in_valid = 1'b0;
        if (acc) begin
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk);
                if (out_valid0) begin
                    lat = k;
                    break;
                end
                @(posedge clk);
            end
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (out_valid0 !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid0); end
        n_cmp++; if ({Yar0, Yai0, Ybr0, Ybi0} !== 64'h0) begin n_bad++; $display("FAIL reset_y got %h want 0", {Yar0, Yai0, Ybr0, Ybi0}); end
        n_cmp++; if (ovf0 !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", ovf0); end
        n_cmp++; if (in_ready0 !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", in_ready0); end
        @(posedge clk); #1 rst = 1'b0;
        $display("reset done");
    endtask

    task automatic test_basic();
        int lat;
        set_in(16384, 0, 8192, 0, 16384, 0, 1'b0);
        send_wait(lat);
        $display("basic lat=%0d Ya=(%0d,%0d) Yb=(%0d,%0d)", lat, Yar0, Yai0, Ybr0, Ybi0);
        n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL basic_latency got %0d want 3", lat); end
        n_cmp++; if ({Yar0, Yai0, Ybr0, Ybi0} !== {16'sd24576, 16'sd0, 16'sd8192, 16'sd0}) begin
            n_bad++; $display("FAIL basic_y got (%0d,%0d,%0d,%0d) want (24576,0,8192,0)", Yar0, Yai0, Ybr0, Ybi0); end
        n_cmp++; if ({Yar1, Ybr1} !== {16'sd12288, 16'sd4096}) begin
            n_bad++; $display("FAIL basic_scaled got (%0d,%0d) want (12288,4096)", Yar1, Ybr1); end
        n_cmp++; if (ovf0 !== 1'b0) begin n_bad++; $display("FAIL basic_ovf got %b want 0", ovf0); end
        repeat (2) @(negedge clk);
        n_cmp++; if (out_valid0 !== 1'b1 || Yar0 !== 16'sd24576) begin
            n_bad++; $display("FAIL basic_hold got v=%b Yar=%0d want v=1 Yar=24576", out_valid0, Yar0); end
        release_out();
    endtask

    task automatic test_conj();
        int lat;
        for (int c = 0; c < 2; c++) begin
            set_in(0, 0, 8192, 0, 0, -16384, 1'(c));
            send_wait(lat);
            $display("conj=%0d Ya=(%0d,%0d) Yb=(%0d,%0d)", c, Yar0, Yai0, Ybr0, Ybi0);
            n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL conj_latency got %0d want 3", lat); end
            n_cmp++;
            if ({Yar0, Yai0, Ybr0, Ybi0} !== {16'sd0, (c == 1) ? 16'sd8192 : -16'sd8192, 16'sd0, (c == 1) ? -16'sd8192 : 16'sd8192}) begin
                n_bad++; $display("FAIL conj_y c=%0d got (%0d,%0d,%0d,%0d)", c, Yar0, Yai0, Ybr0, Ybi0); end
            release_out();
        end
    endtask

    task automatic test_sat();
        int lat;
        set_in(24576, 0, 16384, 0, 16384, 0, 1'b0);
        send_wait(lat);
        $display("sat Ya=(%0d,%0d) Yb=(%0d,%0d) ovf=%b scaled Yar=%0d Ybr=%0d ovf=%b", Yar0, Yai0, Ybr0, Ybi0, ovf0, Yar1, Ybr1, ovf1);
        n_cmp++; if (lat < 0) begin n_bad++; $display("FAIL sat_timeout got %0d want 3", lat); end
        n_cmp++; if ({Yar0, Ybr0} !== {16'sd32767, 16'sd8192}) begin
            n_bad++; $display("FAIL sat_y got (%0d,%0d) want (32767,8192)", Yar0, Ybr0); end
        n_cmp++; if (ovf0 !== 1'b1) begin n_bad++; $display("FAIL sat_ovf got %b want 1", ovf0); end
        n_cmp++; if ({Yar1, Ybr1} !== {16'sd20480, 16'sd4096}) begin
            n_bad++; $display("FAIL sat_scaled got (%0d,%0d) want (20480,4096)", Yar1, Ybr1); end
        n_cmp++; if (ovf1 !== 1'b0) begin n_bad++; $display("FAIL sat_scaled_ovf got %b want 0", ovf1); end
        release_out();
        set_in(16384, 0, 8192, 0, 16384, 0, 1'b0);
        send_wait(lat);
        n_cmp++; if (ovf0 !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %b want 1", ovf0); end
        release_out();
        @(posedge clk); #1 ovf_clr = 1'b1;
        @(posedge clk); #1 ovf_clr = 1'b0;
        @(negedge clk);
        n_cmp++; if (ovf0 !== 1'b0) begin n_bad++; $display("FAIL ovf_clear got %b want 0", ovf0); end
        ovf_clr = 1'b1;
        set_in(24576, 0, 16384, 0, 16384, 0, 1'b0);
        send_wait(lat);
        n_cmp++; if (ovf0 !== 1'b1) begin n_bad++; $display("FAIL ovf_set_wins got %b want 1", ovf0); end
        ovf_clr = 1'b0;
        release_out();
        $display("sat checks done ovf=%b", ovf0);
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int rcv = 0;
        logic had_prev = 1'b0;
        logic [63:0] prev;
        exp_t e;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(posedge clk); #1;
            if (sent < 8) begin
                set_in(1000 * sent + 100, -500 * sent, 2000 + 300 * sent, 700 - 90 * sent,
                       11585 - 500 * sent, 11585 - 2000 * sent, 1'(sent % 2));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = !(cyc >= 6 && cyc < 11);
            @(negedge clk);
            if (!out_ready && out_valid0) begin
                n_cmp++; if (in_ready0 !== 1'b0) begin n_bad++; $display("FAIL b2b_stall_ready cyc %0d got %b want 0", cyc, in_ready0); end
                if (had_prev) begin
                    n_cmp++; if ({Yar0, Yai0, Ybr0, Ybi0} !== prev) begin
                        n_bad++; $display("FAIL b2b_hold cyc %0d got %h want %h", cyc, {Yar0, Yai0, Ybr0, Ybi0}, prev); end
                end
                prev = {Yar0, Yai0, Ybr0, Ybi0};
                had_prev = 1'b1;
            end else begin
                had_prev = 1'b0;
            end
            if (in_valid && in_ready0) begin
                exp_q.push_back(model(Xar, Xai, Xbr, Xbi, Wr, Wi, conj_w));
                sent++;
            end
            if (out_valid0 && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL b2b_extra got output %h want none", {Yar0, Yai0, Ybr0, Ybi0});
                end else begin
                    e = exp_q.pop_front();
                    if ({Yar0, Yai0, Ybr0, Ybi0} !== {e.ar0, e.ai0, e.br0, e.bi0}) begin
                        n_bad++; $display("FAIL b2b_y #%0d got %h want %h", rcv, {Yar0, Yai0, Ybr0, Ybi0}, {e.ar0, e.ai0, e.br0, e.bi0}); end
                    n_cmp++;
                    if ({Yar1, Yai1, Ybr1, Ybi1} !== {e.ar1, e.ai1, e.br1, e.bi1}) begin
                        n_bad++; $display("FAIL b2b_scaled #%0d got %h want %h", rcv, {Yar1, Yai1, Ybr1, Ybi1}, {e.ar1, e.ai1, e.br1, e.bi1}); end
                end
                $display("b2b out %0d Ya=(%0d,%0d) Yb=(%0d,%0d)", rcv, Yar0, Yai0, Ybr0, Ybi0);
                rcv++;
            end
        end
        n_cmp++; if (rcv != 8 || exp_q.size() != 0) begin
            n_bad++; $display("FAIL b2b_count got %0d out (%0d pending) want 8 (0)", rcv, exp_q.size()); end
        exp_q.delete();
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midstream();
        int seen = 0;
        @(negedge clk);
        n_cmp++; if (ovf0 !== 1'b1) begin n_bad++; $display("FAIL mid_ovf_pre got %b want 1", ovf0); end
        @(posedge clk); #1 set_in(100, 200, 300, 400, 16384, 0, 1'b0); in_valid = 1'b1;
        @(posedge clk); #1 set_in(500, 600, 700, 800, 0, 16384, 1'b0);
        @(posedge clk); #1 in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (out_valid0 !== 1'b0) begin n_bad++; $display("FAIL mid_valid got %b want 0", out_valid0); end
        n_cmp++; if ({Yar0, Yai0, Ybr0, Ybi0} !== 64'h0) begin n_bad++; $display("FAIL mid_y got %h want 0", {Yar0, Yai0, Ybr0, Ybi0}); end
        n_cmp++; if ({ovf0, ovf1} !== 2'b00) begin n_bad++; $display("FAIL mid_ovf got %b want 00", {ovf0, ovf1}); end
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (out_valid0 || out_valid1) seen++;
        end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL mid_stale got %0d outputs want 0", seen); end
        $display("reset midstream done");
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int sent = 0;
        int rcv = 0;
        int cyc = 0;
        logic acc = 1'b1;
        exp_t e;
        while (rcv < 300 && cyc < 5000) begin
            @(posedge clk); #1;
            if (!in_valid || acc) begin
                if (sent < 300 && ($urandom % 4 != 0)) begin
                    rand_in();
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom % 4 != 0);
            @(negedge clk);
            acc = in_valid && in_ready0;
            if (acc) begin
                exp_q.push_back(model(Xar, Xai, Xbr, Xbi, Wr, Wi, conj_w));
                sent++;
            end
            if (out_valid0 && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL rnd_extra got output %h want none", {Yar0, Yai0, Ybr0, Ybi0});
                end else begin
                    e = exp_q.pop_front();
                    if ({Yar0, Yai0, Ybr0, Ybi0} !== {e.ar0, e.ai0, e.br0, e.bi0}) begin
                        n_bad++; $display("FAIL rnd_y #%0d got %h want %h", rcv, {Yar0, Yai0, Ybr0, Ybi0}, {e.ar0, e.ai0, e.br0, e.bi0}); end
                    n_cmp++;
                    if ({Yar1, Yai1, Ybr1, Ybi1} !== {e.ar1, e.ai1, e.br1, e.bi1}) begin
                        n_bad++; $display("FAIL rnd_scaled #%0d got %h want %h", rcv, {Yar1, Yai1, Ybr1, Ybi1}, {e.ar1, e.ai1, e.br1, e.bi1}); end
                end
                $display("rnd out %0d Ya=(%0d,%0d) Yb=(%0d,%0d)", rcv, Yar0, Yai0, Ybr0, Ybi0);
                rcv++;
            end
            cyc++;
        end
        n_cmp++; if (rcv != 300) begin n_bad++; $display("FAIL rnd_count got %0d want 300", rcv); end
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 1'b0);
        test_reset();
        test_basic();
        test_conj();
        test_sat();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
